// File: rtl/lcd_nibble_responder.sv
// HD44780-style responder on the 4-bit LCD write bus: pairs nibbles into bytes, runs the
// command subset and keeps a DDRAM character buffer with a registered read port.
module lcd_nibble_responder #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = 4,
    parameter int unsigned CMD_CYCLES   = 4,
    parameter int unsigned CLEAR_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lcd_e,
    input  logic          lcd_rs,
    input  logic          lcd_rw,
    input  logic          lcd_7,
    input  logic          lcd_6,
    input  logic          lcd_5,
    input  logic          lcd_4,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          byte_valid,
    output logic [7:0]    byte_data,
    output logic          byte_rs,
    output logic [AW-1:0] cursor_addr,
    output logic          display_on,
    output logic          entry_inc,
    output logic          init_done,
    output logic          busy,
    output logic          proto_err
);

    localparam int unsigned CW = $clog2(CLEAR_CYCLES + CMD_CYCLES + DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic [1:0] {StInit8, StHi, StLo} state_e;

    state_e        state_q, state_d;
    logic          e_q, rs_q, rw_q;
    logic [3:0]    d_q;
    logic [3:0]    hi_q;
    logic          hi_rs_q;
    logic [CW-1:0] busy_cnt_q;
    logic [AW:0]   fill_left_q;
    logic [AW-1:0] fill_addr_q;
    logic [7:0]    mem [DEPTH];

    logic          strobe, nibble_ok, nibble_drop, init_accept, exec;
    logic [7:0]    new_byte;
    logic [AW-1:0] cur_inc, cur_dec, set_addr;

    // Falling edge of e, using the bus values captured while e was high.
    assign strobe      = e_q & ~lcd_e & ~rw_q;
    assign busy        = (busy_cnt_q != '0);
    assign nibble_ok   = strobe & ~busy;
    assign nibble_drop = strobe & busy;
    assign new_byte    = {hi_q, d_q};
    assign cur_inc     = (cursor_addr == LAST) ? '0 : cursor_addr + 1'b1;
    assign cur_dec     = (cursor_addr == '0) ? LAST : cursor_addr - 1'b1;
    assign set_addr    = AW'({25'd0, new_byte[6:0]} % DEPTH);

    always_comb begin
        state_d     = state_q;
        init_accept = 1'b0;
        exec        = 1'b0;
        if (nibble_ok) begin
            unique case (state_q)
                StInit8: begin
                    if (!rs_q && d_q == 4'h2) begin
                        init_accept = 1'b1;
                        state_d     = StHi;
                    end
                end
                StHi: state_d = StLo;
                StLo: begin
                    exec    = 1'b1;
                    state_d = StHi;
                end
                default: state_d = StInit8;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit8;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            d_q         <= 4'h0;
            hi_q        <= 4'h0;
            hi_rs_q     <= 1'b0;
            byte_valid  <= 1'b0;
            byte_data   <= 8'h00;
            byte_rs     <= 1'b0;
            cursor_addr <= '0;
            display_on  <= 1'b0;
            entry_inc   <= 1'b1;
            init_done   <= 1'b0;
            proto_err   <= 1'b0;
            busy_cnt_q  <= CW'(DEPTH);
            fill_left_q <= (AW+1)'(DEPTH);
            fill_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            e_q        <= lcd_e;
            byte_valid <= exec;
            if (lcd_e) begin
                rs_q <= lcd_rs;
                rw_q <= lcd_rw;
                d_q  <= {lcd_7, lcd_6, lcd_5, lcd_4};
            end
            if (busy) busy_cnt_q <= busy_cnt_q - 1'b1;
            if (fill_left_q != '0) begin
                fill_left_q <= fill_left_q - 1'b1;
                fill_addr_q <= fill_addr_q + 1'b1;
            end
            if (nibble_drop) proto_err <= 1'b1;
            if (init_accept) init_done <= 1'b1;
            if (nibble_ok && state_q == StHi) begin
                hi_q    <= d_q;
                hi_rs_q <= rs_q;
            end
            if (exec) begin
                byte_data  <= new_byte;
                byte_rs    <= rs_q;
                busy_cnt_q <= CW'(CMD_CYCLES);
                if (hi_rs_q != rs_q) proto_err <= 1'b1;
                if (rs_q) begin
                    cursor_addr <= entry_inc ? cur_inc : cur_dec;
                end else if (new_byte[7]) begin
                    cursor_addr <= set_addr;
                end else if (new_byte[6]) begin
                    // CGRAM address set: nothing modelled
                end else if (new_byte[5]) begin
                    if (new_byte[4]) proto_err <= 1'b1;
                end else if (new_byte[4]) begin
                    if (!new_byte[3]) cursor_addr <= new_byte[2] ? cur_inc : cur_dec;
                end else if (new_byte[3]) begin
                    display_on <= new_byte[2];
                end else if (new_byte[2]) begin
                    entry_inc <= new_byte[1];
                end else if (new_byte[1]) begin
                    cursor_addr <= '0;
                end else if (new_byte[0]) begin
                    cursor_addr <= '0;
                    entry_inc   <= 1'b1;
                    busy_cnt_q  <= CW'(CLEAR_CYCLES);
                    fill_left_q <= (AW+1)'(DEPTH);
                    fill_addr_q <= '0;
                end
            end
        end
    end

    // Read samples before the write lands, so a same-cycle write returns the old value.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= 8'h00;
        else     rd_data <= mem[rd_addr];
        if (fill_left_q != '0) mem[fill_addr_q] <= BLANK;
        else if (exec && rs_q && !rst) mem[cursor_addr] <= new_byte;
    end

endmodule

// File: tb/tb_lcd_nibble_responder.sv
// Directed bench for lcd_nibble_responder; assembled bytes are checked against a
// scoreboard queue filled as bytes are driven.
module tb_lcd_nibble_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic       lcd_7 = 1'b0, lcd_6 = 1'b0, lcd_5 = 1'b0, lcd_4 = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    logic [7:0] rd_data, byte_data;
    logic       byte_valid, byte_rs, display_on, entry_inc, init_done, busy, proto_err;
    logic [3:0] cursor_addr;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         pulses = 0;
    int         run = 0;
    int         last_run = 0;

    lcd_nibble_responder #(
        .DEPTH(16), .AW(4), .CMD_CYCLES(4), .CLEAR_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_7(lcd_7), .lcd_6(lcd_6), .lcd_5(lcd_5), .lcd_4(lcd_4),
        .rd_addr(rd_addr), .rd_data(rd_data), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_rs(byte_rs), .cursor_addr(cursor_addr),
        .display_on(display_on), .entry_inc(entry_inc), .init_done(init_done),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on each byte_valid pulse; also tracks busy run lengths.
    always @(negedge clk) begin
        if (!rst && byte_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte_valid", {23'd0, byte_rs, byte_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("byte_out", {23'd0, byte_rs, byte_data}, {23'd0, e});
            end
        end
        if (busy === 1'b1) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic raw_nib(input logic rs, input logic [3:0] d);
        lcd_rs = rs;
        lcd_rw = 1'b0;
        {lcd_7, lcd_6, lcd_5, lcd_4} = d;
        lcd_e = 1'b1;
        @(negedge clk);
        lcd_e = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_nib(input logic rs, input logic [3:0] d);
        wait_idle();
        raw_nib(rs, d);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        send_nib(rs, b[7:4]);
        send_nib(rs, b[3:0]);
    endtask

    task automatic check_mem(input string tag, input logic [3:0] a, input logic [7:0] v);
        rd_addr = a;
        @(negedge clk);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(v));
    endtask

    task automatic check_all_blank(input string tag);
        for (int i = 0; i < 16; i++) check_mem(tag, 4'(i), 8'h20);
    endtask

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_display_on", 32'(display_on), 32'd0);
        check("rst_entry_inc", 32'(entry_inc), 32'd1);
        check("rst_cursor", 32'(cursor_addr), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_fill_busy", 32'(busy), 32'd1);

        // Init: stray nibbles in INIT8 are ignored
        send_nib(1'b0, 4'h3);
        send_nib(1'b1, 4'h2);
        check("init_ignored", 32'(init_done), 32'd0);
        send_nib(1'b0, 4'h2);
        check("init_done_set", 32'(init_done), 32'd1);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b0, 8'h0C);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h06);
        wait_idle();
        check("t1_display_on", 32'(display_on), 32'd1);
        check("t1_entry_inc", 32'(entry_inc), 32'd1);
        check("t1_cursor", 32'(cursor_addr), 32'd0);
        check("t1_proto_err", 32'(proto_err), 32'd0);
        check_all_blank("t1_ddram");

        // Text write
        send_byte(1'b1, 8'h46);
        send_byte(1'b1, 8'h75);
        send_byte(1'b1, 8'h6C);
        send_byte(1'b1, 8'h6C);
        wait_idle();
        check_mem("t2_ddram0", 4'd0, 8'h46);
        check_mem("t2_ddram1", 4'd1, 8'h75);
        check_mem("t2_ddram2", 4'd2, 8'h6C);
        check_mem("t2_ddram3", 4'd3, 8'h6C);
        check("t2_cursor", 32'(cursor_addr), 32'd4);

        // Address set near the end, then wrap 15 -> 0
        send_byte(1'b0, 8'h8F);
        send_byte(1'b1, 8'h41);
        send_byte(1'b1, 8'h42);
        wait_idle();
        check_mem("t3_ddram15", 4'd15, 8'h41);
        check_mem("t3_ddram0", 4'd0, 8'h42);
        check("t3_cursor", 32'(cursor_addr), 32'd1);

        // Decrement mode wraps 0 -> 15
        send_byte(1'b0, 8'h80);
        send_byte(1'b0, 8'h04);
        wait_idle();
        check("t4_entry_inc", 32'(entry_inc), 32'd0);
        send_byte(1'b1, 8'h78);
        wait_idle();
        check_mem("t4_ddram0", 4'd0, 8'h78);
        check("t4_cursor", 32'(cursor_addr), 32'd15);

        // Clear with a strobe landing inside the busy window
        send_byte(1'b0, 8'h01);
        repeat (3) @(negedge clk);
        raw_nib(1'b0, 4'h5);
        wait_idle();
        @(negedge clk);
        check("t5_proto_err", 32'(proto_err), 32'd1);
        check("t5_busy_len", 32'(last_run), 32'd32);
        check("t5_cursor", 32'(cursor_addr), 32'd0);
        check("t5_entry_inc", 32'(entry_inc), 32'd1);
        check_all_blank("t5_ddram");
        send_byte(1'b0, 8'h06);
        wait_idle();

        // Reset with a pending high nibble
        send_nib(1'b1, 4'h4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_init_cleared", 32'(init_done), 32'd0);
        p0 = pulses;
        send_nib(1'b0, 4'h2);
        send_byte(1'b0, 8'h2C);
        wait_idle();
        check("t6_pulses", 32'(pulses - p0), 32'd1);
        check("t6_proto_err", 32'(proto_err), 32'd0);
        check("t6_init_done", 32'(init_done), 32'd1);
        check("t6_cursor", 32'(cursor_addr), 32'd0);
        check_mem("t6_ddram0", 4'd0, 8'h20);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
